// File: rtl/mem_responder.sv
// Word-addressed memory responder for the MAR/MDR interface: accepts one
// read or write per strobe edge and completes it with a done pulse after LATENCY edges.
module mem_responder #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 32,
  parameter int LATENCY    = 2
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic                  read,
  input  logic                  write,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  done,
  output logic                  busy,
  output logic                  err
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;
  localparam int         DEPTH    = 1 << ADDR_WIDTH;
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  logic [1:0]            state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  armed_q, armed_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  op_wr_q, op_wr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  mem_we;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    armed_d = armed_q;
    err_d   = 1'b0;
    rdata_d = rdata_q;
    op_wr_d = op_wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    mem_we  = 1'b0;

    // Re-arming needs both strobes low, so a strobe held across done cannot retrigger.
    if (!read && !write) armed_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (armed_q && (read ^ write)) begin
          state_d = S_ACCESS;
          cnt_d   = CNT_LOAD;
          armed_d = 1'b0;
          op_wr_d = write;
          addr_d  = address;
          wdata_d = wdata;
        end else if (armed_q && read && write) begin
          err_d = 1'b1;
        end
      end
      S_ACCESS: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = S_DONE;
          if (op_wr_q) mem_we  = 1'b1;
          else         rdata_d = mem[addr_q];
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      armed_q <= 1'b1;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      armed_q <= armed_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // Request latches carry no reset; they are only consumed after an acceptance.
  always_ff @(posedge clock) begin
    op_wr_q <= op_wr_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
  end

  // A clear on the commit edge aborts the write.
  always_ff @(posedge clock) begin
    if (mem_we && !clear) mem[addr_q] <= wdata_q;
  end

  assign rdata = rdata_q;
  assign done  = (state_q == S_DONE);
  assign busy  = (state_q != S_IDLE);
  assign err   = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: directed scenarios plus randomized accesses checked
// against a transaction-level memory model.
module tb_mem_responder;

  localparam int L = 2;

  logic        clock = 1'b0;
  logic        clear, read, write;
  logic [8:0]  address;
  logic [31:0] wdata, rdata;
  logic        done, busy, err;

  logic        sread;
  logic [8:0]  saddr;
  logic [31:0] swdata, rdata1, rdata4;
  logic        done1, busy1, err1, done4, busy4, err4;

  logic [31:0] mdr;
  logic [31:0] ref_mem [512];
  logic [31:0] last_rd;
  logic [8:0]  pool [8];
  int          n_chk = 0;
  int          n_bad = 0;

  always #5 clock = ~clock;

  mem_responder #(.ADDR_WIDTH(9), .DATA_WIDTH(32), .LATENCY(L)) dut (
    .clock(clock), .clear(clear), .read(read), .write(write),
    .address(address), .wdata(wdata), .rdata(rdata),
    .done(done), .busy(busy), .err(err));

  mem_responder #(.ADDR_WIDTH(9), .DATA_WIDTH(32), .LATENCY(1)) dut1 (
    .clock(clock), .clear(clear), .read(sread), .write(1'b0),
    .address(saddr), .wdata(swdata), .rdata(rdata1),
    .done(done1), .busy(busy1), .err(err1));

  mem_responder #(.ADDR_WIDTH(9), .DATA_WIDTH(32), .LATENCY(4)) dut4 (
    .clock(clock), .clear(clear), .read(sread), .write(1'b0),
    .address(saddr), .wdata(swdata), .rdata(rdata4),
    .done(done4), .busy(busy4), .err(err4));

  // Datapath-side MDR that captures memory data on done.
  always @(posedge clock) if (done) mdr <= rdata;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // One complete access starting from an idle, armed responder; strobe dropped in the done cycle.
  task automatic do_access(input bit wr, input logic [8:0] a, input logic [31:0] d,
                           input bit scramble);
    read = !wr; write = wr; address = a; wdata = d;
    tick();
    chk("busy_accept", {31'd0, busy}, 32'd1);
    if (scramble) begin
      address = 9'($urandom);
      wdata   = $urandom;
    end
    for (int j = 1; j <= L + 1; j++) begin
      tick();
      chk("done_timing", {31'd0, done}, {31'd0, (j == L)});
      chk("busy_timing", {31'd0, busy}, {31'd0, (j <= L)});
      if (j == L) begin
        if (wr) ref_mem[a] = d;
        else    last_rd    = ref_mem[a];
        chk(wr ? "rdata_after_wr" : "rdata_read", rdata, last_rd);
        read = 1'b0; write = 1'b0;
      end
    end
  endtask

  initial begin
    int ndone;
    clear = 1'b1; read = 1'b0; write = 1'b0; address = '0; wdata = '0;
    sread = 1'b0; saddr = '0; swdata = '0;
    last_rd = '0;
    repeat (3) tick();
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    clear = 1'b0;
    tick();

    // Latency sweep on the LATENCY=1 and LATENCY=4 instances.
    sread = 1'b1;
    tick();
    sread = 1'b0;
    chk("l1_busy0", {31'd0, busy1}, 32'd1);
    chk("l4_busy0", {31'd0, busy4}, 32'd1);
    for (int j = 1; j <= 6; j++) begin
      tick();
      chk("l1_done", {31'd0, done1}, {31'd0, (j == 1)});
      chk("l1_busy", {31'd0, busy1}, {31'd0, (j <= 1)});
      chk("l4_done", {31'd0, done4}, {31'd0, (j == 4)});
      chk("l4_busy", {31'd0, busy4}, {31'd0, (j <= 4)});
    end

    // Write then read.
    do_access(1'b1, 9'h054, 32'hF000_0002, 1'b0);
    do_access(1'b0, 9'h054, 32'h0, 1'b0);
    chk("wr_rd_054", rdata, 32'hF000_0002);

    // Instruction fetch into the MDR.
    do_access(1'b1, 9'h000, 32'h2800_0000, 1'b0);
    do_access(1'b0, 9'h000, 32'h0, 1'b0);
    chk("fetch_mdr", mdr, 32'h2800_0000);

    // Held read strobe yields a single access.
    read = 1'b1; address = 9'h000;
    ndone = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done) ndone++;
    end
    chk("held_ndone", 32'(ndone), 32'd1);
    chk("held_busy", {31'd0, busy}, 32'd0);
    last_rd = ref_mem[9'h000];
    chk("held_rdata", rdata, last_rd);
    read = 1'b0;
    tick();
    do_access(1'b0, 9'h000, 32'h0, 1'b0);

    // Both strobes: error pulse, no access.
    do_access(1'b1, 9'h010, 32'h0000_00A5, 1'b0);
    read = 1'b1; write = 1'b1; address = 9'h010; wdata = 32'h1234_5678;
    tick();
    chk("both_err", {31'd0, err}, 32'd1);
    chk("both_done", {31'd0, done}, 32'd0);
    chk("both_busy", {31'd0, busy}, 32'd0);
    read = 1'b0; write = 1'b0;
    tick();
    chk("both_err_clr", {31'd0, err}, 32'd0);
    chk("both_busy2", {31'd0, busy}, 32'd0);
    do_access(1'b0, 9'h010, 32'h0, 1'b0);
    chk("both_prior", rdata, 32'h0000_00A5);

    // Clear one cycle after a write is accepted.
    do_access(1'b1, 9'h020, 32'h0000_0005, 1'b0);
    write = 1'b1; address = 9'h020; wdata = 32'hDEAD_BEEF;
    tick();
    clear = 1'b1; write = 1'b0;
    tick();
    clear = 1'b0;
    last_rd = '0;
    chk("clr_busy", {31'd0, busy}, 32'd0);
    chk("clr_rdata", rdata, 32'd0);
    ndone = 0;
    for (int i = 0; i < 5; i++) begin
      if (done) ndone++;
      tick();
    end
    chk("clr_no_done", 32'(ndone), 32'd0);
    do_access(1'b0, 9'h020, 32'h0, 1'b0);
    chk("clr_kept", rdata, 32'h0000_0005);

    // Randomized traffic over a small address pool to exercise read-after-write.
    for (int i = 0; i < 8; i++) begin
      pool[i] = 9'(i * 37 + 3);
      do_access(1'b1, pool[i], $urandom, 1'b0);
    end
    for (int i = 0; i < 40; i++) begin
      do_access(1'($urandom_range(0, 1)), pool[$urandom_range(0, 7)], $urandom,
                1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) tick();
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
